// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: signed 32x32 -> 64, one Booth digit per cycle.
// Operands arrive on a valid/ready handshake; the product is held on a valid/ready output.
module booth_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result
);

    localparam int unsigned OP_W   = 32;
    localparam int unsigned PP_W   = OP_W + 1;
    localparam int unsigned ACC_W  = 2 * OP_W;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q;
    logic [OP_W-1:0]    a_q;
    // Multiplier with the implicit B[-1]=0 appended; shifted right two bits per digit.
    logic [PP_W-1:0]    b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic               in_ready_q;
    logic               busy_q;
    logic               out_valid_q;

    logic [2:0]         code_d;
    logic [PP_W-1:0]    mag_d;
    logic [PP_W-1:0]    pp_d;
    logic [1:0]         h_d;
    logic               neg_d;
    logic [ACC_W-1:0]   addend_d;
    logic [ACC_W-1:0]   acc_d;

    // Booth encoder: negative digits are one's complement plus an h=01 LSB correction.
    always_comb begin
        code_d = b_q[2:0];
        mag_d  = '0;
        neg_d  = 1'b0;
        case (code_d)
            3'b001, 3'b010: mag_d = {a_q[OP_W-1], a_q};
            3'b011:         mag_d = {a_q, 1'b0};
            3'b100: begin
                mag_d = {a_q, 1'b0};
                neg_d = 1'b1;
            end
            3'b101, 3'b110: begin
                mag_d = {a_q[OP_W-1], a_q};
                neg_d = 1'b1;
            end
            default: mag_d = '0;
        endcase
        pp_d     = neg_d ? ~mag_d : mag_d;
        h_d      = {1'b0, neg_d};
        addend_d = ({{(ACC_W-PP_W){pp_d[PP_W-1]}}, pp_d} + ACC_W'(h_d)) << {cnt_q, 1'b0};
        acc_d    = acc_q + addend_d;
    end

    // Sequencer; flush takes priority over both handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= CALC;
                        a_q        <= a;
                        b_q        <= {b, 1'b0};
                        cnt_q      <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    b_q   <= {{2{b_q[PP_W-1]}}, b_q[PP_W-1:2]};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(15)) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign result    = acc_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed spec cases, abort cases and
// randomised signed operands against an arithmetic reference product.
module tb_booth_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int n_assert = 0;
    int n_fail   = 0;

    booth_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        return sx * sy;
    endfunction

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One full transaction; outputs sampled on the falling edge (cycle index = edges since capture).
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic [63:0] exp,
                         input int hold, input bit pulse, input bit chk_lat);
        int cyc;
        @(negedge clk);
        chk1("in_ready_idle", in_ready, 1'b1);
        a = av; b = bv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            if (cyc == 1 || cyc == 16) chk1("busy_calc", busy, 1'b1);
            if (cyc == 2) chk1("in_ready_calc", in_ready, 1'b0);
            @(negedge clk);
            cyc++;
        end
        chk1("out_valid_rise", out_valid, 1'b1);
        if (chk_lat) chk64("latency", 64'(cyc), 64'd17);
        chk64("result", result, exp);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            if (pulse && i == 3) begin
                in_valid = 1'b1; a = $urandom; b = $urandom;
                chk1("in_ready_held", in_ready, 1'b0);
            end
            @(negedge clk);
            in_valid = 1'b0;
            chk1("out_valid_held", out_valid, 1'b1);
            chk64("result_held", result, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk1("out_valid_drop", out_valid, 1'b0);
        chk1("in_ready_back", in_ready, 1'b1);
        if (pulse) begin
            @(negedge clk);
            chk1("pulse_not_taken", busy, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rose;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        a = '0; b = '0;
        #12;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk64("rst_result", result, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 1'b0, 1'b1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0, 1'b0, 1'b1);
        do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 1'b0, 1'b1);
        do_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 0, 1'b0, 1'b1);
        do_op(32'h1234_5678, 32'h0000_0000, 64'h0, 0, 1'b0, 1'b1);
        do_op(32'h1234_5678, 32'h9ABC_DEF0, ref_mul(32'h1234_5678, 32'h9ABC_DEF0), 10, 1'b1, 1'b1);

        // Flush at cycle 8 of CALC with a competing in_valid.
        @(negedge clk);
        a = 32'd1000; b = 32'd2000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk1("flush_in_ready", in_ready, 1'b1);
        chk1("flush_busy", busy, 1'b0);
        chk64("flush_result", result, 64'h0);
        rose = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        chk1("flush_no_out_valid", rose, 1'b0);
        chk1("flush_in_valid_ignored", busy, 1'b0);

        // Reset mid-CALC.
        a = 32'd77; b = 32'd88; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk64("midrst_result", result, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(-32'sd7, 32'sd6, 64'hFFFF_FFFF_FFFF_FFD6, 0, 1'b0, 1'b1);

        // Randomised operands with random output backpressure.
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = $urandom;
            case (k % 8)
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'h5555_5555;
                default: ;
            endcase
            do_op(ra, rb, ref_mul(ra, rb), int'($urandom_range(0, 3)), 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Iterative radix-4 Booth multiplier sequencer: accepts a signed 32x32 operand pair over a valid/ready handshake and produces the signed 64-bit product. It retires one Booth digit per cycle, 16 digits in total. The block owns the multiplicand/multiplier registers, the digit counter and the 64-bit accumulator. It drives the team's radix-4 Booth encoder (33-bit partial product, 2-bit `h` correction, sign-compensation bit `s`) and sits between the ALU issue stage and the writeback mux.

## Interface
- No parameters. Widths are fixed: 32-bit operands, 64-bit result.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept operands.
- `a` in 32: multiplicand, two's complement.
- `b` in 32: multiplier, two's complement.
- `flush` in 1: synchronous abort of any in-flight or unconsumed operation.
- `busy` out 1: iteration in progress.
- `out_valid` out 1: `result` valid.
- `out_ready` in 1: consumer accepts `result`.
- `result` out 64: signed product a*b.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `a`→A and `b`→B, clear the accumulator, set count=0, go to CALC.
- CALC:
  - Each cycle, form code = {B[2i+1], B[2i], B[2i-1]} for i = count, with B[-1]=0.
  - Apply the encoder mapping: 000/111→0, 001/010→+A, 011→+2A, 100→−2A, 101/110→−A.
  - Negative digits are produced as one's-complement plus the `h`=01 LSB correction.
  - Add the sign-extended partial product, weighted by 4^i, to the 64-bit accumulator. Arithmetic is modulo 2^64.
  - Implementation may shift the accumulator right by 2 per step or shift the partial product left. Only the final `result` is checked.
  - After count=15 is processed, go to DONE.
- DONE:
  - `out_valid`=1 and `result` holds the product, both stable until the handshake.
  - When `out_ready`=1, go to IDLE.
- `busy` = (state == CALC). `in_ready` = (state == IDLE). No new operand is accepted in CALC or DONE.
- `flush`=1 in any state:
  - Go to IDLE next cycle and deassert `out_valid`.
  - `result` is cleared to 0.
  - `in_valid` in the same cycle is ignored.
- `flush` has priority over `in_valid` and `out_ready`.
- Operand registers are not affected by later changes on `a` and `b` after capture.
- Reset (async, `rst_n`=0):
  - State IDLE, count=0, accumulator/`result`=0, A=B=0.
  - `out_valid`=0, `busy`=0, `in_ready`=1 (visible immediately on assertion).
  - A reset mid-operation discards the operation; no partial result is ever presented.

## Timing
- Cycle 0: IDLE with `in_valid`=1; capture on the rising edge.
- Cycles 1–16: CALC, one digit per cycle, `busy`=1.
- Cycle 17: `out_valid`=1. Latency is 17 cycles from capture edge to `out_valid`.
- With `out_ready` held high, `in_ready` returns at cycle 18. Minimum initiation interval is 18 cycles.
- `out_valid` may be held indefinitely under backpressure; `result` must not change while held.
- All outputs are registered or decoded from registered state only; there is no combinational path from `in_valid` or `out_ready` to `out_valid`.
- Latency is fixed: no early termination. Zero and all-ones multipliers take the full 16 cycles.

## Test plan
- `a`=3, `b`=5, `out_ready`=1 → `out_valid` at cycle 17, `result`=0x000000000000000F, `in_ready` high at cycle 18.
- `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → `result`=0x0000000000000001.
- `a`=0x80000000, `b`=0x80000000 → `result`=0x4000000000000000.
- `a`=0x7FFFFFFF, `b`=0x80000000 → `result`=0xC000000080000000.
- Hold `out_ready`=0 for 10 cycles after `out_valid`; pulse `in_valid` during that window with new operands:
  - `result` stays stable and the pulse is not accepted (`in_ready`=0).
  - After `out_ready`, one transfer only, then IDLE.
- Abort cases:
  - Assert `flush` at cycle 8 of CALC → IDLE next cycle, `out_valid` never rises, `result`=0.
  - Drop `rst_n` mid-CALC, then release and issue `a`=−7, `b`=6 → `result`=0xFFFFFFFFFFFFFFD6.
- Randomised signed pairs against a reference model, with random `out_ready` backpressure.
